// File: rtl/pcm_frame_assembler_if.sv
// -----------------------------------------------------------------------------
// pcm_frame_assembler_if
//
// Purpose:
//   Groups the byte input from uart_rx and the write port into the sample
//   fifo, which together make up the data path of pcm_frame_assembler.
//
// Signals:
//   rx_data       8   received byte, valid only while rx_received is high
//   rx_received   1   single-cycle byte strobe from uart_rx
//   fifo_full     1   fifo full flag, looked at when a frame completes
//   fifo_wr_en    1   single-cycle write strobe into the fifo
//   fifo_wr_data  32  assembled stereo frame {left[15:0], right[15:0]}
//
// Modports:
//   master  environment side: drives the byte stream and the full flag,
//           receives the fifo writes
//   slave   the assembler itself
// -----------------------------------------------------------------------------
interface pcm_frame_assembler_if;
    logic [7:0]  rx_data;
    logic        rx_received;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;

    modport master (
        output rx_data,
        output rx_received,
        output fifo_full,
        input  fifo_wr_en,
        input  fifo_wr_data
    );

    modport slave (
        input  rx_data,
        input  rx_received,
        input  fifo_full,
        output fifo_wr_en,
        output fifo_wr_data
    );
endinterface

// File: rtl/pcm_frame_assembler.sv
// -----------------------------------------------------------------------------
// pcm_frame_assembler
//
// Purpose:
//   Sits between uart_rx and the sample fifo of the DAC board audio path.
//   Four received bytes are collected into one 32-bit stereo PCM frame
//   (left sample in [31:16], right sample in [15:0]) and written into the
//   fifo with a single-cycle strobe. Byte order on the wire is
//   left LSB, left MSB, right LSB, right MSB.
//
//   A partially received frame is abandoned when the line stays idle for
//   GAP_BYTES byte times, which re-aligns the byte stream after a gap.
//   Frames completing while the fifo is full are dropped and counted.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   bus            pcm_frame_assembler_if.slave: rx_data, rx_received,
//                  fifo_full in; fifo_wr_en, fifo_wr_data out
//   busy           high while 1 to 3 bytes of a frame are held
//   frame_error    one-cycle pulse when a partial frame times out
//   overrun        one-cycle pulse when a complete frame is dropped
//   overrun_count  saturating (255) count of dropped frames
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUDRATE   UART bit rate in baud
//   GAP_BYTES  idle time, in byte times (10 bits each), that aborts a frame
//
// Configuration macro:
//   PCM_FRAME_ASSEMBLER_SIGNED_IN_EN
//     defined   : samples arrive as two's complement; bits 31 and 15 are
//                 inverted when a frame is latched, giving offset binary
//     undefined : samples pass through unchanged (offset binary on the wire)
// -----------------------------------------------------------------------------
module pcm_frame_assembler #(
    parameter int unsigned CLK_FREQ  = 120_000_000,
    parameter int unsigned BAUDRATE  = 3_000_000,
    parameter int unsigned GAP_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pcm_frame_assembler_if.slave bus,
    output logic                 busy,
    output logic                 frame_error,
    output logic                 overrun,
    output logic [7:0]           overrun_count
);

    // The product overflows 32 bits with the default parameters, so the
    // gap length is computed in 64 bits before being narrowed.
    localparam logic [63:0] GAP_CYCLES_WIDE =
        64'(GAP_BYTES) * 64'd10 * 64'(CLK_FREQ) / 64'(BAUDRATE);
    localparam int unsigned GAP_CYCLES = 32'(GAP_CYCLES_WIDE);
    localparam int unsigned GAP_W      = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        BYTE3 = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [GAP_W-1:0] gap_count;
    logic [GAP_W-1:0] gap_count_next;
    logic [GAP_W-1:0] gap_count_inc;
    logic             gap_expire;

    logic [7:0]       left_lsb;
    logic [7:0]       left_lsb_next;
    logic [7:0]       left_msb;
    logic [7:0]       left_msb_next;
    logic [7:0]       right_lsb;
    logic [7:0]       right_lsb_next;

    logic             wr_en;
    logic             wr_en_next;
    logic [31:0]      wr_data;
    logic [31:0]      wr_data_next;
    logic             frame_error_next;
    logic             overrun_next;
    logic [7:0]       overrun_count_next;

    // Converts a completed frame to the format the sigma-delta DAC expects.
    // With signed input, flipping each sample's sign bit turns two's
    // complement into offset binary.
    function automatic logic [31:0] to_dac_format(input logic [31:0] frame);
`ifdef PCM_FRAME_ASSEMBLER_SIGNED_IN_EN
        return frame ^ 32'h8000_8000;
`else
        return frame;
`endif
    endfunction

    // The counter holds the number of idle cycles seen since the last byte.
    // The gap expires on the idle cycle that would bring it to GAP_CYCLES,
    // so the counter itself never has to hold that value for a cycle.
    assign gap_count_inc = gap_count + GAP_W'(1);
    assign gap_expire    = (state != BYTE0) && (gap_count_inc == GAP_LIMIT);

    // Next-state, byte staging and output decisions. A byte strobe always
    // takes priority over the gap expiring in the same cycle, and the gap
    // logic is inert in BYTE0 so an idle line between frames is harmless.
    always_comb begin
        state_next         = state;
        gap_count_next     = gap_count;
        left_lsb_next      = left_lsb;
        left_msb_next      = left_msb;
        right_lsb_next     = right_lsb;
        wr_en_next         = 1'b0;
        wr_data_next       = wr_data;
        frame_error_next   = 1'b0;
        overrun_next       = 1'b0;
        overrun_count_next = overrun_count;

        if (bus.rx_received) begin
            gap_count_next = '0;
            unique case (state)
                BYTE0: begin
                    left_lsb_next = bus.rx_data;
                    state_next    = BYTE1;
                end
                BYTE1: begin
                    left_msb_next = bus.rx_data;
                    state_next    = BYTE2;
                end
                BYTE2: begin
                    right_lsb_next = bus.rx_data;
                    state_next     = BYTE3;
                end
                BYTE3: begin
                    // The right MSB is used straight from the bus, so the
                    // frame can be written in the cycle after the strobe.
                    state_next     = BYTE0;
                    left_lsb_next  = '0;
                    left_msb_next  = '0;
                    right_lsb_next = '0;
                    if (bus.fifo_full) begin
                        overrun_next = 1'b1;
                        if (overrun_count != 8'hFF) begin
                            overrun_count_next = overrun_count + 8'd1;
                        end
                    end else begin
                        wr_en_next   = 1'b1;
                        wr_data_next = to_dac_format({left_msb, left_lsb,
                                                      bus.rx_data, right_lsb});
                    end
                end
            endcase
        end else if (gap_expire) begin
            state_next       = BYTE0;
            gap_count_next   = '0;
            left_lsb_next    = '0;
            left_msb_next    = '0;
            right_lsb_next   = '0;
            frame_error_next = 1'b1;
        end else if (state != BYTE0) begin
            gap_count_next = gap_count_inc;
        end
    end

    // State and output registers. Reset drops any partial frame and clears
    // the overrun statistics as well as the last written frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= BYTE0;
            gap_count     <= '0;
            left_lsb      <= '0;
            left_msb      <= '0;
            right_lsb     <= '0;
            wr_en         <= 1'b0;
            wr_data       <= '0;
            frame_error   <= 1'b0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            state         <= state_next;
            gap_count     <= gap_count_next;
            left_lsb      <= left_lsb_next;
            left_msb      <= left_msb_next;
            right_lsb     <= right_lsb_next;
            wr_en         <= wr_en_next;
            wr_data       <= wr_data_next;
            frame_error   <= frame_error_next;
            overrun       <= overrun_next;
            overrun_count <= overrun_count_next;
        end
    end

    assign busy             = (state != BYTE0);
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_data = wr_data;

endmodule
